// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, iteration count.
// Latency: n/a (types and helpers only); backpressure: n/a.
package mult_div_unit_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } mdu_state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline controller and the multiply/divide unit.
// Latency: n/a (wiring only); backpressure: start is honoured only while busy is low.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, input busy, done, hi, lo);
  modport slave  (input start, op, opA, opB, output busy, done, hi, lo);

endinterface

// File: rtl/mult_div_unit_iter_core.sv
// Step datapath: shift-add multiply or restoring divide on unsigned magnitudes, one bit per step.
// Latency: 32 steps after load; backpressure: none, advances only when step is high.
module mult_div_unit_iter_core
  import mult_div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sreg,
  output logic             last
);

  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] count;
  logic             div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] rem_diff;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sreg_nxt;

  // Multiply: {acc,sreg} shifts right as the multiplier bits are consumed.
  // Divide: acc is the partial remainder, sreg shifts quotient bits in from the right.
  always_comb begin
    add_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_shift = {acc, sreg[WIDTH-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_q};
    acc_nxt   = add_sum[WIDTH:1];
    sreg_nxt  = {add_sum[0], sreg[WIDTH-1:1]};
    if (div_q) begin
      if (rem_diff[WIDTH+1]) begin
        acc_nxt  = rem_shift[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt  = rem_diff[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      sreg  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      sreg  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
      count <= '0;
    end else if (step) begin
      acc   <= acc_nxt;
      sreg  <= sreg_nxt;
      count <= count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(ITER_COUNT - 1));

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in 33 cycles (busy meanwhile, done on result), MTHI/MTLO in one.
// Backpressure: start is ignored while busy; nothing is queued.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  mdu_state_e state, state_nxt;

  logic             accept;
  logic             load, step, commit, busy;
  logic             last;
  logic             now_signed, now_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc, sreg;

  logic             op_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic             done_q;
  logic [2*WIDTH-1:0] product;

  assign accept     = (state == ST_IDLE) && bus.start && is_iter_op(bus.op);
  assign now_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign now_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
  assign a_mag      = magnitude(bus.opA, now_signed);
  assign b_mag      = magnitude(bus.opB, now_signed);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_RUN;
      ST_RUN:    if (last)   state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    load   = accept;
    step   = (state == ST_RUN);
    commit = (state == ST_COMMIT);
  end

  mult_div_unit_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (now_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .sreg   (sreg),
    .last   (last)
  );

  // Signs are held as zero for unsigned ops so the commit fixup is a no-op for them.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_div   <= now_div;
      sign_a   <= now_signed & bus.opA[WIDTH-1];
      sign_b   <= now_signed & bus.opB[WIDTH-1];
      div_zero <= (bus.opB == '0);
    end
  end

  // With a zero divisor every trial subtract succeeds, so the remainder is the
  // dividend magnitude and its sign fixup reproduces opA; only LO needs forcing.
  always_comb begin
    product = {acc, sreg};
    if (sign_a ^ sign_b) product = -product;
    if (op_div) begin
      res_lo = div_zero ? '1 : ((sign_a ^ sign_b) ? -sreg : sreg);
      res_hi = sign_a ? -acc : acc;
    end else begin
      res_lo = product[WIDTH-1:0];
      res_hi = product[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if ((state == ST_IDLE) && bus.start) begin
        if (bus.op == MDU_MTHI) hi_q <= bus.opA;
        if (bus.op == MDU_MTLO) lo_q <= bus.opA;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table through a result scoreboard, plus hand sequences for
// reset mid-operation, start while busy, and MTHI/MTLO.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];
  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; the next edge (E0) accepts, returns at E0+#1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input res_t exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opA   = 32'hDEAD_BEEF;
    bus.opB   = 32'hDEAD_BEEF;
  endtask

  // Waits for done (bounded), compares latency, busy length and the scoreboard head.
  // When inject > 0 a DIVU start is driven for one cycle at that cycle of the run.
  task automatic wait_result(input string tag, input int inject);
    int   lat;
    int   busy_cyc;
    res_t exp;
    lat      = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && lat < 60) begin
      if (lat == inject) begin
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.opA   = 32'd55;
        bus.opB   = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required 33", tag, lat);
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'd33);
    check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: done with no expected result queued", tag);
      return;
    end
    exp = sb_q.pop_front();
    check({tag, " hi"}, bus.hi, exp.hi);
    check({tag, " lo"}, bus.lo, exp.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_seen;
    res_t none;
    none = '0;

    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    vecs[4] = '{MDU_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{MDU_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800};

    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.opA   = '0;
    bus.opB   = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table runs back to back: each start lands in the done cycle of the previous op.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, '{vecs[i].exp_hi, vecs[i].exp_lo});
      wait_result($sformatf("vec%0d", i), -1);
    end

    // Start during busy must be dropped and not disturb the running result.
    @(posedge clk); #1;
    issue(MDU_MULTU, 32'd100, 32'd3, 1'b1, '{32'd0, 32'd300});
    wait_result("busy_start", 5);
    @(posedge clk); #1;
    check("busy_start done_pulse", {31'd0, bus.done}, 32'd0);
    check("busy_start no_queue", {31'd0, bus.busy}, 32'd0);
    check("busy_start lo_held", bus.lo, 32'd300);

    // Reset at iteration 10 of a MULT discards it.
    issue(MDU_MULT, 32'd7, 32'd9, 1'b0, none);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset done", {31'd0, bus.done}, 32'd0);
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("midreset no_late_done", 32'(done_seen), 32'd0);

    // MTHI then MTLO on consecutive cycles, then an ignored op 6.
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.opA   = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    check("mthi hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi lo", bus.lo, 32'd0);
    check("mthi busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    bus.op  = MDU_MTLO;
    bus.opA = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    check("mtlo lo", bus.lo, 32'h5A5A_5A5A);
    check("mtlo hi", bus.hi, 32'hA5A5_A5A5);
    check("mtlo busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    bus.op  = 3'd6;
    bus.opA = 32'h1111_1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("nop hi", bus.hi, 32'hA5A5_A5A5);
    check("nop lo", bus.lo, 32'h5A5A_5A5A);
    check("nop busy_done", {30'd0, bus.busy, bus.done}, 32'd0);

    // Unit must work normally after a mid-operation reset.
    issue(vecs[2].op, vecs[2].a, vecs[2].b, 1'b1, '{vecs[2].exp_hi, vecs[2].exp_lo});
    wait_result("post_reset", -1);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
